// File: rtl/motor_pkg.sv
// Shared types, FSM state encodings and command-decode helpers for the
// two-channel motor command sequencer.
package motor_pkg;

  localparam int MAX_DUTY_DEFAULT = 100;

  typedef logic [7:0] duty_t;

  typedef logic [1:0] motor_state_t;
  localparam motor_state_t RAMP  = 2'd0;
  localparam motor_state_t DECEL = 2'd1;
  localparam motor_state_t DEAD  = 2'd2;

  // Magnitude of a signed command; -128 maps to 128 before clamping.
  function automatic duty_t cmd_to_mag(input logic [7:0] cmd, input duty_t max_duty);
    duty_t mag;
    mag = cmd[7] ? (8'd0 - cmd) : cmd;
    if (mag > max_duty) mag = max_duty;
    return mag;
  endfunction

  // A zero command keeps whatever direction the motor already has.
  function automatic logic cmd_to_dir(input logic [7:0] cmd, input logic cur_dir);
    if (cmd == 8'd0) return cur_dir;
    return ~cmd[7];
  endfunction

endpackage

// File: rtl/motor_cmd_sequencer_if.sv
// Command handshake between the balance-loop command source (master) and
// the sequencer (slave).
interface motor_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_motor1;
  logic [7:0] cmd_motor2;

  modport master (output cmd_valid, output cmd_motor1, output cmd_motor2, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_motor1, input cmd_motor2, output cmd_ready);
endinterface

// File: rtl/motor_ramp.sv
// One motor channel: slew-limited duty, decel-to-zero and coast dead-time
// before any direction reversal. Advances only on period_tick.
module motor_ramp
  import motor_pkg::*;
#(
  parameter int STEP             = 4,
  parameter int DEADTIME_PERIODS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       period_tick,
  input  logic       target_dir,
  input  duty_t      target_mag,
  output logic       sign,
  output logic [6:0] upperlimit,
  output logic       hold
);
  localparam int CNT_W = (DEADTIME_PERIODS < 1) ? 1 : $clog2(DEADTIME_PERIODS + 1);
  localparam duty_t STEP_D = duty_t'(STEP);

  motor_state_t      state_reg, state_next;
  duty_t             mag_reg, mag_next, dec_mag;
  logic              sign_reg, sign_next, hold_reg;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  assign dec_mag = (mag_reg > STEP_D) ? (mag_reg - STEP_D) : '0;

  always_comb begin
    state_next = state_reg;
    mag_next   = mag_reg;
    sign_next  = sign_reg;
    cnt_next   = cnt_reg;
    if (period_tick) begin
      case (state_reg)
        RAMP: begin
          if (target_dir != sign_reg) begin
            state_next = DECEL;
          end else if (mag_reg < target_mag) begin
            mag_next = ((target_mag - mag_reg) > STEP_D) ? (mag_reg + STEP_D) : target_mag;
          end else if (mag_reg > target_mag) begin
            mag_next = ((mag_reg - target_mag) > STEP_D) ? (mag_reg - STEP_D) : target_mag;
          end
        end
        DECEL: begin
          if (target_dir == sign_reg) begin
            state_next = RAMP;
          end else begin
            mag_next = dec_mag;
            if (dec_mag == '0) begin
              state_next = DEAD;
              cnt_next   = CNT_W'(DEADTIME_PERIODS);
            end
          end
        end
        DEAD: begin
          // Flip on the tick that takes the counter to zero; ramping starts next tick.
          if (target_dir == sign_reg) begin
            state_next = RAMP;
          end else if (cnt_reg <= CNT_W'(1)) begin
            cnt_next   = '0;
            sign_next  = ~sign_reg;
            state_next = RAMP;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        default: state_next = RAMP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RAMP;
      mag_reg   <= '0;
      sign_reg  <= 1'b1;
      cnt_reg   <= '0;
      hold_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      mag_reg   <= mag_next;
      sign_reg  <= sign_next;
      cnt_reg   <= cnt_next;
      hold_reg  <= (mag_next == '0) || (state_next == DEAD);
    end
  end

  assign sign       = sign_reg;
  assign upperlimit = mag_reg[6:0];
  assign hold       = hold_reg;
endmodule

// File: rtl/motor_cmd_sequencer.sv
// Command handshake, pending register and watchdog feeding two motor_ramp
// channels; new targets take effect only at PWM period boundaries.
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int MAX_DUTY         = MAX_DUTY_DEFAULT,
  parameter int STEP             = 4,
  parameter int DEADTIME_PERIODS = 2,
  parameter int TIMEOUT_PERIODS  = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 period_tick,
  motor_cmd_sequencer_if.slave cmd,
  output logic                 motor1_sign,
  output logic [6:0]           motor1_upperlimit,
  output logic                 motor1_hold,
  output logic                 motor2_sign,
  output logic [6:0]           motor2_upperlimit,
  output logic                 motor2_hold,
  output logic                 fault_timeout
);
  localparam int WD_W = $clog2(TIMEOUT_PERIODS + 1);

  logic             pending_reg, fault_reg;
  logic [WD_W-1:0]  wd_reg, wd_next;
  logic             accept, apply, timeout_next;
  logic [1:0][7:0]  cmd_in;
  logic [1:0]       sign_w, hold_w;
  logic [1:0][6:0]  upper_w;

  assign cmd_in[0]     = cmd.cmd_motor1;
  assign cmd_in[1]     = cmd.cmd_motor2;
  assign cmd.cmd_ready = ~pending_reg;
  assign accept        = cmd.cmd_valid && ~pending_reg;
  assign apply         = period_tick && pending_reg;

  // Accept wins over an expiring watchdog in the same cycle.
  always_comb begin
    wd_next = wd_reg;
    if (accept) begin
      wd_next = '0;
    end else if (period_tick && (wd_reg != WD_W'(TIMEOUT_PERIODS))) begin
      wd_next = wd_reg + 1'b1;
    end
  end
  assign timeout_next = (wd_next == WD_W'(TIMEOUT_PERIODS));

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
      wd_reg      <= '0;
      fault_reg   <= 1'b0;
    end else begin
      if (accept) pending_reg <= 1'b1;
      else if (apply) pending_reg <= 1'b0;
      wd_reg    <= wd_next;
      fault_reg <= timeout_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_motor
      logic [7:0] pend_reg;
      logic       tgt_dir_reg, tgt_dir_next;
      duty_t      tgt_mag_reg, tgt_mag_next;

      // The ramp sees the target being applied on this very tick.
      always_comb begin
        tgt_dir_next = tgt_dir_reg;
        tgt_mag_next = tgt_mag_reg;
        if (apply) begin
          tgt_dir_next = cmd_to_dir(pend_reg, sign_w[gi]);
          tgt_mag_next = cmd_to_mag(pend_reg, duty_t'(MAX_DUTY));
        end else if (timeout_next) begin
          tgt_mag_next = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          pend_reg    <= '0;
          tgt_dir_reg <= 1'b1;
          tgt_mag_reg <= '0;
        end else begin
          if (accept) pend_reg <= cmd_in[gi];
          tgt_dir_reg <= tgt_dir_next;
          tgt_mag_reg <= tgt_mag_next;
        end
      end

      motor_ramp #(
        .STEP             (STEP),
        .DEADTIME_PERIODS (DEADTIME_PERIODS)
      ) u_ramp (
        .clk         (clk),
        .reset       (reset),
        .period_tick (period_tick),
        .target_dir  (tgt_dir_next),
        .target_mag  (tgt_mag_next),
        .sign        (sign_w[gi]),
        .upperlimit  (upper_w[gi]),
        .hold        (hold_w[gi])
      );
    end
  endgenerate

  assign motor1_sign       = sign_w[0];
  assign motor1_upperlimit = upper_w[0];
  assign motor1_hold       = hold_w[0];
  assign motor2_sign       = sign_w[1];
  assign motor2_upperlimit = upper_w[1];
  assign motor2_hold       = hold_w[1];
  assign fault_timeout     = fault_reg;
endmodule
